// File: rtl/hack_mem_pkg.sv
// Shared types and default widths for the SDRAM request arbiter.
package hack_mem_pkg;

   localparam int unsigned AW_DEFAULT = 20;
   localparam int unsigned DW_DEFAULT = 16;

   typedef enum logic {
      ARB   = 1'b0,
      ISSUE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of channel tags for reads in flight to the SDRAM buffer.
module tag_fifo #(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 head,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot in the same cycle, so push+pop is legal when full.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are DEPTH-sized (power of two), so they wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter funnelling per-channel memory requests into one SDRAM
// buffer port, routing in-order read returns back to the issuing channel.
module mem_req_arbiter
   import hack_mem_pkg::*;
#(
   parameter int unsigned NCH   = 2,
   parameter int unsigned AW    = AW_DEFAULT,
   parameter int unsigned DW    = DW_DEFAULT,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk50,
   input  logic                         reset,
   input  logic [NCH-1:0]               req_valid,
   input  logic [NCH-1:0]               req_we,
   input  logic [NCH*AW-1:0]            req_addr,
   input  logic [NCH*DW-1:0]            req_wdata,
   output logic [NCH-1:0]               req_ready,
   output logic [NCH-1:0]               rsp_valid,
   output logic [DW-1:0]                rsp_data,
   output logic                         buf_wrreq,
   output logic [AW-1:0]                buf_addr,
   output logic [DW-1:0]                buf_data,
   output logic                         buf_rw,
   input  logic                         buf_full,
   input  logic                         rd_valid,
   input  logic [DW-1:0]                rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         err_orphan
);

   localparam int unsigned TW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   arb_state_t     state;
   arb_state_t     next_state;
   logic [TW-1:0]  rr_ptr;
   logic [TW-1:0]  rr_next;
   logic [TW-1:0]  gnt;
   logic [TW-1:0]  tag_q;
   logic [TW:0]    cand;
   logic [NCH-1:0] elig;
   logic [NCH-1:0] grant_oh;
   logic           found;
   logic           rd_room;
   logic           take;

   logic           fifo_push;
   logic           fifo_pop;
   logic [TW-1:0]  fifo_head;
   logic           fifo_empty;

   // Read room comes from the registered count only, keeping req_ready free of rd_valid.
   assign rd_room = (outstanding < CW'(DEPTH));

   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         elig[i] = req_valid[i] & ~buf_full & (req_we[i] | rd_room);
      end
   end

   // First eligible channel at or after rr_ptr, modulo NCH.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cand = {1'b0, rr_ptr} + (TW+1)'(i);
         if (cand >= (TW+1)'(NCH)) begin
            cand = cand - (TW+1)'(NCH);
         end
         if (!found && elig[cand[TW-1:0]]) begin
            found = 1'b1;
            gnt   = cand[TW-1:0];
         end
      end
   end

   always_comb begin
      rr_next = gnt + TW'(1);
      if (32'(gnt) == NCH - 1) begin
         rr_next = '0;
      end
   end

   assign grant_oh = NCH'(1) << gnt;

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state <= ARB;
      end else begin
         state <= next_state;
      end
   end

   // Next state and the acceptance strobe, which must coincide with the grant cycle.
   always_comb begin
      next_state = state;
      take       = 1'b0;
      req_ready  = '0;
      case (state)
         ARB: begin
            if (found) begin
               take       = 1'b1;
               next_state = ISSUE;
               if (!reset) begin
                  req_ready = grant_oh;
               end
            end
         end
         ISSUE: begin
            next_state = ARB;
         end
         default: begin
            next_state = ARB;
         end
      endcase
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         tag_q     <= '0;
         buf_wrreq <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
         buf_rw    <= 1'b0;
      end else begin
         buf_wrreq <= take;
         if (take) begin
            rr_ptr   <= rr_next;
            tag_q    <= gnt;
            buf_addr <= req_addr[gnt*AW +: AW];
            buf_data <= req_wdata[gnt*DW +: DW];
            buf_rw   <= req_we[gnt];
         end
      end
   end

   assign fifo_push = (state == ISSUE) && !buf_rw;
   assign fifo_pop  = rd_valid && !fifo_empty;

   tag_fifo #(
      .W     (TW),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk50),
      .rst       (reset),
      .push      (fifo_push),
      .push_data (tag_q),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (outstanding)
   );

   // Read return steering; data with no read in flight is dropped and flagged.
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         rsp_valid  <= '0;
         rsp_data   <= '0;
         err_orphan <= 1'b0;
      end else begin
         rsp_valid <= fifo_pop ? (NCH'(1) << fifo_head) : '0;
         if (fifo_pop) begin
            rsp_data <= rd_data;
         end
         if (rd_valid && fifo_empty) begin
            err_orphan <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: writes, read returns, round-robin,
// depth limit, backpressure, orphan data and reset during issue.
module tb_mem_req_arbiter;

   localparam int unsigned NCH   = 2;
   localparam int unsigned AW    = 20;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic              clk50;
   logic              reset;
   logic [NCH-1:0]    req_valid;
   logic [NCH-1:0]    req_we;
   logic [NCH*AW-1:0] req_addr;
   logic [NCH*DW-1:0] req_wdata;
   logic [NCH-1:0]    req_ready;
   logic [NCH-1:0]    rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              buf_wrreq;
   logic [AW-1:0]     buf_addr;
   logic [DW-1:0]     buf_data;
   logic              buf_rw;
   logic              buf_full;
   logic              rd_valid;
   logic [DW-1:0]     rd_data;
   logic [CW-1:0]     outstanding;
   logic              err_orphan;

   int n_checks = 0;
   int n_fail   = 0;

   mem_req_arbiter #(
      .NCH   (NCH),
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk50       (clk50),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .buf_wrreq   (buf_wrreq),
      .buf_addr    (buf_addr),
      .buf_data    (buf_data),
      .buf_rw      (buf_rw),
      .buf_full    (buf_full),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .outstanding (outstanding),
      .err_orphan  (err_orphan)
   );

   initial clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and let outputs settle.
   task automatic step();
      @(negedge clk50);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      buf_full  = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = '0;

      // Reset values, with requests pending to prove req_ready is forced low
      @(negedge clk50);
      req_valid = 2'b11;
      req_we    = 2'b11;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_buf_wrreq", 32'(buf_wrreq), 32'h0);
      chk("rst_outstanding", 32'(outstanding), 32'h0);
      chk("rst_err_orphan", 32'(err_orphan), 32'h0);
      chk("rst_buf_addr", 32'(buf_addr), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);

      @(negedge clk50);
      reset     = 1'b0;
      req_valid = '0;
      req_we    = '0;
      #1;

      // Single write on ch0
      step();
      req_valid       = 2'b01;
      req_we          = 2'b01;
      req_addr[19:0]  = 20'h00010;
      req_wdata[15:0] = 16'hBEEF;
      #1;
      chk("wr_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      #1;
      chk("wr_wrreq", 32'(buf_wrreq), 32'h1);
      chk("wr_rw", 32'(buf_rw), 32'h1);
      chk("wr_addr", 32'(buf_addr), 32'h00010);
      chk("wr_data", 32'(buf_data), 32'hBEEF);
      chk("wr_ready_issue", 32'(req_ready), 32'h0);
      step();
      chk("wr_wrreq_drop", 32'(buf_wrreq), 32'h0);
      chk("wr_addr_hold", 32'(buf_addr), 32'h00010);

      // Read on ch1 and its return (rr_ptr is now 1)
      req_valid        = 2'b10;
      req_we           = 2'b00;
      req_addr[39:20]  = 20'h00020;
      #1;
      chk("rd_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      #1;
      chk("rd_wrreq", 32'(buf_wrreq), 32'h1);
      chk("rd_rw", 32'(buf_rw), 32'h0);
      chk("rd_addr", 32'(buf_addr), 32'h00020);
      step();
      chk("rd_outstanding1", 32'(outstanding), 32'h1);
      rd_valid = 1'b1;
      rd_data  = 16'h1234;
      #1;
      chk("rd_rsp_early", 32'(rsp_valid), 32'h0);
      step();
      rd_valid = 1'b0;
      #1;
      chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("rd_rsp_data", 32'(rsp_data), 32'h1234);
      chk("rd_outstanding0", 32'(outstanding), 32'h0);
      step();
      chk("rd_rsp_drop", 32'(rsp_valid), 32'h0);

      // Round-robin between two continuous writers (rr_ptr is now 0)
      req_valid        = 2'b11;
      req_we           = 2'b11;
      req_addr[19:0]   = 20'h00100;
      req_addr[39:20]  = 20'h00200;
      req_wdata        = {16'h5555, 16'hAAAA};
      #1;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            chk("rr_ready", 32'(req_ready), ((k / 2) % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_wrreq_idle", 32'(buf_wrreq), 32'h0);
         end else begin
            chk("rr_ready_issue", 32'(req_ready), 32'h0);
            chk("rr_wrreq", 32'(buf_wrreq), 32'h1);
            chk("rr_addr", 32'(buf_addr), ((k / 2) % 2 == 0) ? 32'h00100 : 32'h00200);
            chk("rr_data", 32'(buf_data), ((k / 2) % 2 == 0) ? 32'hAAAA : 32'h5555);
         end
         step();
      end
      req_valid = '0;
      #1;
      chk("rr_idle", 32'(req_ready), 32'h0);

      // Depth limit: ch1 reads back to back with no returns
      req_valid        = 2'b10;
      req_we           = 2'b00;
      req_addr[39:20]  = 20'h00300;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("dp_outstanding", 32'(outstanding), 32'(k / 2));
         if (k % 2 == 0) begin
            chk("dp_ready", 32'(req_ready), 32'h2);
         end else begin
            chk("dp_wrreq", 32'(buf_wrreq), 32'h1);
         end
         step();
      end
      chk("dp_full_ready", 32'(req_ready), 32'h0);
      chk("dp_full_outstanding", 32'(outstanding), 32'h4);
      req_valid        = 2'b11;
      req_we           = 2'b01;
      req_addr[19:0]   = 20'h00077;
      req_wdata[15:0]  = 16'h0777;
      #1;
      chk("dp_write_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b10;
      req_we    = 2'b00;
      #1;
      chk("dp_write_wrreq", 32'(buf_wrreq), 32'h1);
      chk("dp_write_rw", 32'(buf_rw), 32'h1);
      chk("dp_write_addr", 32'(buf_addr), 32'h00077);
      step();
      chk("dp_blocked", 32'(req_ready), 32'h0);
      chk("dp_blocked_outstanding", 32'(outstanding), 32'h4);
      rd_valid = 1'b1;
      rd_data  = 16'h0001;
      #1;
      chk("dp_ready_indep_rdvalid", 32'(req_ready), 32'h0);
      step();
      rd_valid = 1'b0;
      #1;
      chk("dp_first_rsp", 32'(rsp_valid), 32'h2);
      chk("dp_first_data", 32'(rsp_data), 32'h0001);
      chk("dp_first_outstanding", 32'(outstanding), 32'h3);
      chk("dp_fifth_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      #1;
      chk("dp_fifth_wrreq", 32'(buf_wrreq), 32'h1);
      chk("dp_fifth_rw", 32'(buf_rw), 32'h0);
      step();
      chk("dp_refill", 32'(outstanding), 32'h4);
      rd_valid = 1'b1;
      rd_data  = 16'h0011;
      for (int j = 0; j < 4; j++) begin
         step();
         if (j < 3) begin
            rd_data = 16'(16'h0012 + j);
         end else begin
            rd_valid = 1'b0;
         end
         #1;
         chk("dp_drain_rsp", 32'(rsp_valid), 32'h2);
         chk("dp_drain_data", 32'(rsp_data), 32'(16'h0011 + j));
         chk("dp_drain_outstanding", 32'(outstanding), 32'(3 - j));
      end
      step();
      chk("dp_drain_done", 32'(rsp_valid), 32'h0);

      // Backpressure
      buf_full  = 1'b1;
      req_valid = 2'b11;
      req_we    = 2'b11;
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      step();
      chk("bp_ready2", 32'(req_ready), 32'h0);
      chk("bp_wrreq", 32'(buf_wrreq), 32'h0);
      buf_full  = 1'b0;
      req_valid = '0;

      // Orphan read data
      rd_valid = 1'b1;
      rd_data  = 16'hDEAD;
      step();
      rd_valid = 1'b0;
      #1;
      chk("orph_rsp", 32'(rsp_valid), 32'h0);
      chk("orph_err", 32'(err_orphan), 32'h1);
      chk("orph_outstanding", 32'(outstanding), 32'h0);
      step();
      chk("orph_sticky", 32'(err_orphan), 32'h1);

      // Reset during ISSUE (rr_ptr is 0 here)
      req_valid        = 2'b10;
      req_we           = 2'b00;
      req_addr[39:20]  = 20'h00040;
      #1;
      chk("rm_read_ready", 32'(req_ready), 32'h2);
      step();
      req_valid        = 2'b01;
      req_we           = 2'b01;
      req_addr[19:0]   = 20'h00050;
      req_wdata[15:0]  = 16'h5050;
      #1;
      chk("rm_ready_issue", 32'(req_ready), 32'h0);
      step();
      chk("rm_outstanding1", 32'(outstanding), 32'h1);
      chk("rm_write_ready", 32'(req_ready), 32'h1);
      step();
      chk("rm_wrreq_before", 32'(buf_wrreq), 32'h1);
      reset = 1'b1;
      #1;
      chk("rm_wrreq_killed", 32'(buf_wrreq), 32'h0);
      chk("rm_outstanding0", 32'(outstanding), 32'h0);
      chk("rm_err_cleared", 32'(err_orphan), 32'h0);
      chk("rm_addr_cleared", 32'(buf_addr), 32'h0);
      chk("rm_data_cleared", 32'(buf_data), 32'h0);
      chk("rm_ready_in_reset", 32'(req_ready), 32'h0);
      step();
      reset     = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b11;
      #1;
      chk("rm_first_grant", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      #1;
      chk("rm_after_wrreq", 32'(buf_wrreq), 32'h1);
      chk("rm_after_addr", 32'(buf_addr), 32'h00050);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
